// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - HUB75 scan generator and shifter for a 64x64, 1/32-scan LED panel
// Sweeps x/y/subframe/frame to the painter and serialises its rgb samples onto the panel pins.
module led_scan_driver #(
   parameter int SUBFRAMES = 256
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [12:0] frame,
   output logic [7:0]  subframe,
   output logic [5:0]  x,
   output logic [5:0]  y,
   input  logic [2:0]  rgb,
   output logic [15:0] LED_PANEL
);

   typedef enum logic [1:0] {SHIFT, TAIL, BLANK, LATCH} state_t;

   localparam logic [7:0] SF_LAST = 8'(SUBFRAMES - 1);

   state_t      state;
   state_t      state_nx;
   logic [6:0]  cnt;
   logic [4:0]  row;
   logic [4:0]  addr;
   logic [2:0]  top_hold;
   logic [5:0]  data;
   logic        shown;
   logic        sclk;
   logic        lat;
   logic        oe_n;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= SHIFT;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SHIFT: if (cnt == 7'd127) state_nx = TAIL;
         TAIL:  if (cnt[0])        state_nx = BLANK;
         BLANK:                    state_nx = LATCH;
         LATCH:                    state_nx = SHIFT;
         default:                  state_nx = SHIFT;
      endcase
   end

   // cnt is {column, phase} in SHIFT and the sclk phase in TAIL; it restarts on every state change.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= 7'd0;
         row      <= 5'd0;
         addr     <= 5'd0;
         top_hold <= 3'd0;
         data     <= 6'd0;
         shown    <= 1'b0;
         subframe <= 8'd0;
         frame    <= 13'd0;
      end else begin
         cnt <= (state_nx != state) ? 7'd0 : cnt + 7'd1;
         if (state == SHIFT && !cnt[0]) top_hold <= rgb;
         if (state == SHIFT && cnt[0])  data     <= {rgb, top_hold};
         if (state == BLANK)            addr     <= row;
         if (state == LATCH) begin
            row   <= row + 5'd1;
            shown <= 1'b1;
            if (row == 5'd31) begin
               if (subframe == SF_LAST) begin
                  subframe <= 8'd0;
                  frame    <= frame + 13'd1;
               end else begin
                  subframe <= subframe + 8'd1;
               end
            end
         end
      end
   end

   // Column 0 never pulses sclk, so each rise clocks the column shifted one step earlier.
   always_comb begin
      x    = cnt[6:1];
      y    = {cnt[0], row};
      sclk = 1'b0;
      lat  = 1'b0;
      oe_n = !shown;
      case (state)
         SHIFT: sclk = cnt[0] && (cnt[6:1] != 6'd0);
         TAIL: begin
            x    = 6'd63;
            y    = {1'b1, row};
            sclk = cnt[0];
         end
         BLANK: begin
            x    = 6'd63;
            y    = {1'b1, row};
            oe_n = 1'b1;
         end
         LATCH: begin
            x    = 6'd63;
            y    = {1'b1, row};
            lat  = 1'b1;
            oe_n = 1'b1;
         end
         default: ;
      endcase
   end

   assign LED_PANEL = {2'b00, oe_n, lat, sclk, addr, data};

endmodule
